// File: rtl/mult_seq_pkg.sv
// Shared types and sizing helpers for the sequential chunked multiplier.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int DEF_A_WIDTH = 32;
  localparam int DEF_B_WIDTH = 32;
  localparam int DEF_A_CHUNK = 8;
  localparam int DEF_B_CHUNK = 16;

  function automatic int num_steps(input int aw, input int ac, input int bw, input int bc);
    return (aw / ac) * (bw / bc);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_seq_datapath.sv
// Operand capture, chunk partial products, shifted accumulation and the
// sign-corrected product register.
module mult_seq_datapath
  import mult_seq_pkg::*;
#(
  parameter int A_WIDTH = DEF_A_WIDTH,
  parameter int B_WIDTH = DEF_B_WIDTH,
  parameter int A_CHUNK = DEF_A_CHUNK,
  parameter int B_CHUNK = DEF_B_CHUNK,
  localparam int IW = idx_width(A_WIDTH / A_CHUNK),
  localparam int JW = idx_width(B_WIDTH / B_CHUNK),
  localparam int PW = A_WIDTH + B_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               signed_mode,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  input  logic               step,
  input  logic [IW-1:0]      i_idx,
  input  logic [JW-1:0]      j_idx,
  input  logic               finish,
  output logic [PW-1:0]      product
);

  localparam int CW = A_CHUNK + B_CHUNK;

  logic [A_WIDTH-1:0] a_reg;
  logic [B_WIDTH-1:0] b_reg;
  logic               neg;
  logic [PW-1:0]      acc;

  logic [A_WIDTH-1:0] a_mag;
  logic [B_WIDTH-1:0] b_mag;
  logic [A_CHUNK-1:0] a_chunk;
  logic [B_CHUNK-1:0] b_chunk;
  logic [CW-1:0]      pp;
  logic [PW-1:0]      term;
  int                 shamt;

  // Magnitudes for signed operands; the most negative value maps onto itself,
  // which is exactly 2^(W-1) when read as unsigned.
  always_comb begin
    a_mag = a;
    b_mag = b;
    if (signed_mode && a[A_WIDTH-1]) begin
      a_mag = -a;
    end else begin
      a_mag = a;
    end
    if (signed_mode && b[B_WIDTH-1]) begin
      b_mag = -b;
    end else begin
      b_mag = b;
    end
  end

  // Chunk select, chunk multiply and alignment of the partial product.
  always_comb begin
    a_chunk = a_reg[int'(i_idx)*A_CHUNK +: A_CHUNK];
    b_chunk = b_reg[int'(j_idx)*B_CHUNK +: B_CHUNK];
    pp      = {{B_CHUNK{1'b0}}, a_chunk} * {{A_CHUNK{1'b0}}, b_chunk};
    shamt   = int'(i_idx) * A_CHUNK + int'(j_idx) * B_CHUNK;
    term    = {{(PW-CW){1'b0}}, pp} << shamt;
  end

  // Operand and sign capture on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg <= '0;
      b_reg <= '0;
      neg   <= 1'b0;
    end else if (load) begin
      a_reg <= a_mag;
      b_reg <= b_mag;
      neg   <= signed_mode & (a[A_WIDTH-1] ^ b[B_WIDTH-1]);
    end
  end

  // Accumulator: cleared on accept, one partial product per step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (load) begin
      acc <= '0;
    end else if (step) begin
      acc <= acc + term;
    end
  end

  // Result register holds until the next completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      product <= '0;
    end else if (finish) begin
      product <= neg ? -acc : acc;
    end
  end

endmodule

// File: rtl/mult_seq_param.sv
// Self-sequenced multi-cycle multiplier: start/busy/done handshake, chunk
// index sequencing and control of the accumulate datapath.
module mult_seq_param
  import mult_seq_pkg::*;
#(
  parameter int A_WIDTH = DEF_A_WIDTH,
  parameter int B_WIDTH = DEF_B_WIDTH,
  parameter int A_CHUNK = DEF_A_CHUNK,
  parameter int B_CHUNK = DEF_B_CHUNK
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       signed_mode,
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  output logic                       busy,
  output logic                       done,
  output logic [A_WIDTH+B_WIDTH-1:0] product
);

  localparam int NA = A_WIDTH / A_CHUNK;
  localparam int NB = B_WIDTH / B_CHUNK;
  localparam int IW = idx_width(NA);
  localparam int JW = idx_width(NB);

  state_t        state;
  state_t        next_state;
  logic          accept;
  logic          step;
  logic          finish;
  logic          last;
  logic [IW-1:0] i_idx;
  logic [JW-1:0] j_idx;

  // Next-state and per-state control strobes.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    last       = (i_idx == IW'(NA - 1)) && (j_idx == JW'(NB - 1));
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          next_state = FIX;
        end else begin
          next_state = RUN;
        end
      end
      FIX: begin
        finish     = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Chunk indices: i is the inner index and wraps as j advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_idx <= '0;
      j_idx <= '0;
    end else if (accept) begin
      i_idx <= '0;
      j_idx <= '0;
    end else if (step) begin
      if (i_idx == IW'(NA - 1)) begin
        i_idx <= '0;
        j_idx <= last ? '0 : j_idx + JW'(1);
      end else begin
        i_idx <= i_idx + IW'(1);
      end
    end
  end

  // Handshake outputs; done coincides with the product update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        busy <= 1'b1;
      end else if (finish) begin
        busy <= 1'b0;
      end
    end
  end

  mult_seq_datapath #(
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (B_WIDTH),
    .A_CHUNK (A_CHUNK),
    .B_CHUNK (B_CHUNK)
  ) u_datapath (
    .clk         (clk),
    .reset       (reset),
    .load        (accept),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .step        (step),
    .i_idx       (i_idx),
    .j_idx       (j_idx),
    .finish      (finish),
    .product     (product)
  );

endmodule

// File: tb/tb_mult_seq_param.sv
// Directed bench for mult_seq_param: default 8x16 chunking plus a 4x8 instance.
module tb_mult_seq_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, sm = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [63:0] product;
  logic        start2 = 1'b0, sm2 = 1'b0;
  logic [31:0] a2 = '0, b2 = '0;
  logic        busy2, done2;
  logic [63:0] product2;

  int tests = 0;
  int fails = 0;

  localparam int N1 = 8;
  localparam int N2 = 32;

  always #5 clk = ~clk;

  mult_seq_param dut (
    .clk(clk), .reset(reset), .start(start), .signed_mode(sm),
    .a(a), .b(b), .busy(busy), .done(done), .product(product)
  );

  mult_seq_param #(.A_WIDTH(32), .B_WIDTH(32), .A_CHUNK(4), .B_CHUNK(8)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .signed_mode(sm2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .product(product2)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sm;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive start for one cycle; returns at the first negedge after the accept edge.
  task automatic launch(input bit use2, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic tsm);
    @(negedge clk);
    if (use2) begin
      start2 = 1'b1; a2 = ta; b2 = tb_v; sm2 = tsm;
    end else begin
      start = 1'b1; a = ta; b = tb_v; sm = tsm;
    end
    @(negedge clk);
    start = 1'b0;
    start2 = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'hDEAD_BEEF; sm = ~sm;
  endtask

  // Wait for done from negedge index m0; returns on the negedge where done is high.
  task automatic wait_done(input bit use2, input int m0, input bit chk_busy,
                           input logic [63:0] exp, input int nsteps, input string name);
    int m;
    int bcnt;
    m = m0;
    bcnt = 0;
    while (!(use2 ? done2 : done) && m < 200) begin
      if (use2 ? busy2 : busy) bcnt++;
      @(negedge clk);
      m++;
    end
    check({name, " latency"}, 64'(m), 64'(nsteps + 1));
    if (chk_busy) check({name, " busy cycles"}, 64'(bcnt), 64'(nsteps + 1));
    check({name, " busy at done"}, {63'd0, use2 ? busy2 : busy}, 64'd0);
    check({name, " product"}, use2 ? product2 : product, exp);
  endtask

  initial begin
    int dcnt;
    vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "umax"};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, "s_m1x5"};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0005, 1'b0, 64'h0000_0004_FFFF_FFFB, "u_m1x5"};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "s_minxmin"};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000, "s_minx1"};
    vecs[5] = '{32'h0000_0000, 32'h1234_5678, 1'b1, 64'h0000_0000_0000_0000, "s_zero"};
    vecs[6] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000, "s_maxxmin"};
    vecs[7] = '{32'h1234_5678, 32'h0000_0010, 1'b0, 64'h0000_0001_2345_6780, "u_shift"};
    vecs[8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFC, 1'b1, 64'h0000_0000_0000_000C, "s_negxneg"};
    vecs[9] = '{32'h0000_0003, 32'h0000_0007, 1'b1, 64'h0000_0000_0000_0015, "s_pos"};

    repeat (2) @(negedge clk);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset product", product, 64'd0);
    check("reset product2", product2, 64'd0);
    reset = 1'b0;

    for (int v = 0; v < 10; v++) begin
      launch(1'b0, vecs[v].a, vecs[v].b, vecs[v].sm);
      wait_done(1'b0, 0, 1'b1, vecs[v].exp, N1, vecs[v].name);
      @(negedge clk);
      check({vecs[v].name, " done width"}, {63'd0, done}, 64'd0);
      check({vecs[v].name, " hold"}, product, vecs[v].exp);
    end

    // Start while busy is ignored; start in the done cycle is accepted.
    launch(1'b0, 32'd3, 32'd7, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, 4, 1'b0, 64'd21, N1, "ignored_start");
    start = 1'b1; a = 32'h0001_0000; b = 32'h0001_0000; sm = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("b2b done width", {63'd0, done}, 64'd0);
    check("b2b busy", {63'd0, busy}, 64'd1);
    check("b2b old product held", product, 64'd21);
    wait_done(1'b0, 0, 1'b1, 64'h0000_0001_0000_0000, N1, "b2b");

    // Reset in the middle of a job.
    launch(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst busy", {63'd0, busy}, 64'd0);
    check("midrst done", {63'd0, done}, 64'd0);
    check("midrst product", product, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    repeat (N1 + 4) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("midrst no done", 64'(dcnt), 64'd0);
    check("midrst idle", {63'd0, busy}, 64'd0);
    launch(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_done(1'b0, 0, 1'b1, 64'h0000_0001_FFFF_FFFE, N1, "restart");

    // Fine-grained chunking: 32 steps.
    launch(1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_done(1'b1, 0, 1'b1, 64'h0000_0001_FFFF_FFFE, N2, "n32_u");
    launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(1'b1, 0, 1'b1, 64'h0000_0000_8000_0000, N2, "n32_s");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_seq_param.md
Name: mult_seq_param

Overview:
- Parametrised, self-sequenced successor to the fixed 32x32 byte/halfword multiplier datapath.
- Accepts an operand pair on a start/busy/done handshake.
- Accumulates one A_CHUNK x B_CHUNK partial product per cycle, with optional two's-complement mode.
- Presents a registered full-width product. Sits beside the ALU as a multi-cycle multiply unit and needs no external controller.

Parameters:
- A_WIDTH, 32, width of operand a; must be a multiple of A_CHUNK.
- B_WIDTH, 32, width of operand b; must be a multiple of B_CHUNK.
- A_CHUNK, 8, bits of a consumed per partial product.
- B_CHUNK, 16, bits of b consumed per partial product.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- signed_mode  in  1  1 = operands and product are two's complement; captured with start.
- a  in  A_WIDTH  multiplicand; captured with start.
- b  in  B_WIDTH  multiplier; captured with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when product is updated.
- product  out  A_WIDTH+B_WIDTH  registered result; holds until the next completion.

Behaviour:
- Constants: NA = A_WIDTH/A_CHUNK, NB = B_WIDTH/B_CHUNK, N = NA*NB. Defaults give 4*2 = 8.
- Reset (async, any state): state=IDLE, busy=0, done=0, product=0, accumulator=0, indices=0.
- States: IDLE, RUN, FIX.
- IDLE:
  - busy=0.
  - On start=1: capture magnitudes |a| and |b| when signed_mode=1 (raw values otherwise) into A_WIDTH/B_WIDTH unsigned registers.
  - Capture neg = signed_mode & (a_msb ^ b_msb).
  - Clear accumulator, set i=0 (a chunk), j=0 (b chunk), go to RUN.
- RUN:
  - busy=1. Each cycle: acc += (a_reg chunk i * b_reg chunk j) << (i*A_CHUNK + j*B_CHUNK).
  - Iteration order: i is the inner index (0..NA-1), j the outer index; i wraps to 0 as j increments.
  - After step N-1 go to FIX. Exactly N RUN cycles.
- FIX:
  - busy=1. product <= neg ? -acc : acc (modulo 2^(A_WIDTH+B_WIDTH)).
  - done <= 1 (registered, high for exactly the next cycle). Go to IDLE.
- Latency: start sampled at edge k gives done=1 and the new product visible after edge k+N+1, i.e. N+2 cycles from the start cycle. Default: 10 cycles.
- Throughput: a start asserted in the cycle done=1 (state IDLE) is accepted. Back-to-back operations therefore take N+2 cycles each.
- start while busy=1: ignored, no queueing; the in-flight operation is unaffected.
- Width rules:
  - Magnitude of the most negative input (e.g. 0x80000000) equals 2^(W-1) and fits in the W-bit unsigned register.
  - Accumulator is A_WIDTH+B_WIDTH bits; no overflow is possible.
  - Partial product is A_CHUNK+B_CHUNK bits.
- signed_mode=0: operands treated as unsigned and neg=0.
- Reset mid-RUN/FIX: operation abandoned, all outputs return to reset values. No done is issued.
- a, b and signed_mode are don't-care outside the start-accept cycle.

Decomposition:
- Package mult_seq_pkg:
  - state enum typedef (IDLE, RUN, FIX).
  - default width/chunk localparams.
  - function returning N for given widths.
- One sub-module, mult_seq_datapath:
  - chunk select muxes for a and b.
  - A_CHUNK x B_CHUNK multiplier.
  - shift by index.
  - accumulator register with clear/update.
  - final conditional negate.
- The top level holds the FSM, index counters and handshake.

Test Plan:
- Unsigned max: a=0xFFFFFFFF, b=0xFFFFFFFF, signed_mode=0, start 1 cycle -> busy high for 9 cycles; done pulses 10 cycles after start; product=0xFFFFFFFE00000001.
- Signed mixed: a=0xFFFFFFFF (-1), b=0x00000005, signed_mode=1 -> product=0xFFFFFFFFFFFFFFFB. Same operands with signed_mode=0 -> 0x00000004FFFFFFFB.
- Signed corner: a=0x80000000, b=0x80000000, signed_mode=1 -> product=0x4000000000000000. a=0x80000000, b=0x00000001 -> 0xFFFFFFFF80000000.
- Busy/back-to-back: start a=3, b=7; re-pulse start with a=9, b=9 in cycle 4 -> ignored, product=21. Start a=0x00010000, b=0x00010000 in the done cycle -> accepted; product=0x0000000100000000 10 cycles later.
- Reset mid-op: assert reset at cycle 5 of a 0xFFFFFFFF*2 job -> busy=0, done=0, product=0 immediately and no done pulse. A restarted job yields 0x00000001FFFFFFFE.
- Reparametrised instance with A_CHUNK=4, B_CHUNK=8 (N=32): a=0xFFFFFFFF, b=0x00000002 unsigned -> done 34 cycles after start, product=0x00000001FFFFFFFE.
